// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the Memory access sequencer.
package mem_ctrl_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 8;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WR,
    RD,
    OUT,
    DONE
  } state_t;

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin arbiter; 'last' remembers which port was granted most recently.
module mem_rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       gnt_en,
  output logic [1:0] gnt
);

  logic last;

  // One-hot grant: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    gnt = 2'b00;
    if (gnt_en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last == PORT_DATA) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Record the granted port; reset value favours the fetch port on the first tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last <= PORT_DATA;
    end else if (gnt[1]) begin
      last <= PORT_DATA;
    end else if (gnt[0]) begin
      last <= PORT_FETCH;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer and two-port arbiter generating the Ain/Din/write/read/Dout strobes for Memory.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  output logic          p0_ack,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_Ain,
  output logic          mem_Din,
  output logic          mem_read,
  output logic          mem_write,
  output logic          mem_Dout,
  output logic [AW-1:0] mem_Abus,
  output logic [DW-1:0] mem_dbus_o,
  output logic          mem_dbus_oe,
  input  logic [DW-1:0] mem_dbus_i
);

  state_t        state, n_state;
  logic          lat_port, n_port;
  logic          lat_we, n_we;
  logic [AW-1:0] lat_addr, n_addr;
  logic [DW-1:0] lat_wdata, n_wdata;
  logic [1:0]    gnt;

  mem_rr_arb2 u_arb (
    .CLK    (CLK),
    .RST    (RST),
    .req    ({p1_req, p0_req}),
    .gnt_en (state == IDLE),
    .gnt    (gnt)
  );

  // Next state and next request latch; the latch only loads on a grant in IDLE.
  always_comb begin
    n_state = state;
    n_port  = lat_port;
    n_we    = lat_we;
    n_addr  = lat_addr;
    n_wdata = lat_wdata;
    unique case (state)
      IDLE: begin
        if (gnt[1]) begin
          n_state = ADDR;
          n_port  = PORT_DATA;
          n_we    = p1_we;
          n_addr  = p1_addr;
          n_wdata = p1_wdata;
        end else if (gnt[0]) begin
          n_state = ADDR;
          n_port  = PORT_FETCH;
          n_we    = 1'b0;
          n_addr  = p0_addr;
          n_wdata = '0;
        end
      end
      ADDR:    n_state = lat_we ? WR : RD;
      WR:      n_state = DONE;
      RD:      n_state = OUT;
      OUT:     n_state = DONE;
      DONE:    n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end

  // State, request latch and outputs; outputs are registered from the next state
  // so each one is a clean Moore decode of the state being entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      lat_port    <= PORT_FETCH;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rdata       <= '0;
      busy        <= 1'b0;
      p0_ack      <= 1'b0;
      p1_ack      <= 1'b0;
      mem_Ain     <= 1'b0;
      mem_Din     <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_Dout    <= 1'b0;
      mem_Abus    <= '0;
      mem_dbus_o  <= '0;
      mem_dbus_oe <= 1'b0;
    end else begin
      state       <= n_state;
      lat_port    <= n_port;
      lat_we      <= n_we;
      lat_addr    <= n_addr;
      lat_wdata   <= n_wdata;
      if (state == OUT) begin
        rdata <= mem_dbus_i;
      end
      busy        <= (n_state != IDLE);
      p0_ack      <= (n_state == DONE) && (n_port == PORT_FETCH);
      p1_ack      <= (n_state == DONE) && (n_port == PORT_DATA);
      mem_Ain     <= (n_state == ADDR);
      mem_Din     <= (n_state == ADDR) && n_we;
      mem_read    <= (n_state == RD);
      mem_write   <= (n_state == WR);
      mem_Dout    <= (n_state == OUT);
      mem_Abus    <= (n_state == IDLE) ? '0 : n_addr;
      mem_dbus_o  <= ((n_state == ADDR) && n_we) ? n_wdata : '0;
      mem_dbus_oe <= (n_state == ADDR) && n_we;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural Memory model and ack scoreboard.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       p0_req = 1'b0;
  logic [4:0] p0_addr = '0;
  logic       p0_ack;
  logic       p1_req = 1'b0;
  logic       p1_we = 1'b0;
  logic [4:0] p1_addr = '0;
  logic [7:0] p1_wdata = '0;
  logic       p1_ack;
  logic [7:0] rdata;
  logic       busy;
  logic       mem_Ain, mem_Din, mem_read, mem_write, mem_Dout;
  logic [4:0] mem_Abus;
  logic [7:0] mem_dbus_o;
  logic       mem_dbus_oe;
  logic [7:0] mem_dbus_i;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         port;
    bit         rd;
    logic [7:0] data;
  } exp_t;
  exp_t sbq[$];

  always #5 CLK = ~CLK;

  mem_access_ctrl #(.AW(5), .DW(8)) dut (
    .CLK(CLK), .RST(RST),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
    .rdata(rdata), .busy(busy),
    .mem_Ain(mem_Ain), .mem_Din(mem_Din), .mem_read(mem_read), .mem_write(mem_write),
    .mem_Dout(mem_Dout), .mem_Abus(mem_Abus), .mem_dbus_o(mem_dbus_o),
    .mem_dbus_oe(mem_dbus_oe), .mem_dbus_i(mem_dbus_i)
  );

  // Behavioural 32x8 Memory block
  logic [7:0] mem [32];
  logic [4:0] m_areg;
  logic [7:0] m_dreg;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 13) + 7);
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = pat(i);
    m_areg = '0;
    m_dreg = '0;
  end

  assign mem_dbus_i = mem_Dout ? m_dreg : (mem_dbus_oe ? mem_dbus_o : 8'h00);

  always @(posedge CLK) begin
    if (mem_Ain) m_areg <= mem_Abus;
    if (mem_Din) m_dreg <= mem_dbus_i;
    if (mem_write) mem[m_areg] <= m_dreg;
    if (mem_read) m_dreg <= mem[m_areg];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic wait_ack(input int port, input int limit);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!(port == 1 ? p1_ack : p0_ack) && n < limit);
    check($sformatf("ack%0d_seen", port), port == 1 ? p1_ack : p0_ack, 1);
  endtask

  // Scoreboard and invariants, sampled on the falling edge
  always @(negedge CLK) begin
    check("oe_dout_excl", mem_dbus_oe & mem_Dout, 0);
    check("busy_vs_state", busy, dut.state != IDLE);
    if (p0_ack || p1_ack) begin
      check("single_ack", p0_ack & p1_ack, 0);
      if (sbq.size() == 0) begin
        check("sb_unexpected_ack", {p1_ack, p0_ack}, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_port", p1_ack ? 1 : 0, e.port);
        if (e.rd) check("sb_rdata", rdata, e.data);
      end
    end
  end

  initial begin
    int cycles, idle;

    // reset
    cyc(); cyc();
    check("rst_outs", {p0_ack, p1_ack, busy, mem_Ain, mem_Din, mem_read, mem_write,
                       mem_Dout, mem_dbus_oe}, 0);
    check("rst_abus", mem_Abus, 0);
    check("rst_rdata", rdata, 0);
    RST = 1'b0;

    // port-1 write addr 1 = FF
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 5'd1; p1_wdata = 8'hFF;
    sbq.push_back('{port: 1, rd: 1'b0, data: 8'h00});
    cyc();
    check("w_addr_strobes", {mem_Ain, mem_Din, mem_dbus_oe, mem_write, mem_read}, 5'b11100);
    check("w_abus", mem_Abus, 1);
    check("w_dbus_o", mem_dbus_o, 8'hFF);
    cyc();
    check("w_wr_strobes", {mem_Ain, mem_Din, mem_dbus_oe, mem_write}, 4'b0001);
    check("w_wr_abus", mem_Abus, 1);
    cyc();
    check("w_ack_3cyc", {p1_ack, mem_write}, 2'b10);
    p1_req = 1'b0; p1_we = 1'b0;
    cyc();
    check("w_idle", {busy, mem_Abus}, 0);
    check("w_mem1", mem[1], 8'hFF);

    // port-0 read addr 1
    p0_req = 1'b1; p0_addr = 5'd1;
    sbq.push_back('{port: 0, rd: 1'b1, data: 8'hFF});
    cyc();
    check("r_addr_strobes", {mem_Ain, mem_Din, mem_dbus_oe}, 3'b100);
    check("r_abus", mem_Abus, 1);
    cyc();
    check("r_rd_strobe", {mem_read, mem_Ain}, 2'b10);
    cyc();
    check("r_out_strobe", {mem_Dout, mem_dbus_oe, mem_read}, 3'b100);
    cyc();
    check("r_ack_4cyc", p0_ack, 1);
    check("r_rdata", rdata, 8'hFF);
    p0_req = 1'b0;
    cyc();
    check("r_rdata_hold", rdata, 8'hFF);

    // tie from reset: p0 first; with p0 held, p1 wins the next tie
    RST = 1'b1; cyc(); RST = 1'b0;
    p0_req = 1'b1; p0_addr = 5'd1;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 5'd3;
    sbq.push_back('{port: 0, rd: 1'b1, data: 8'hFF});
    sbq.push_back('{port: 1, rd: 1'b1, data: pat(3)});
    sbq.push_back('{port: 0, rd: 1'b1, data: 8'hFF});
    cyc();
    check("tie1_abus_p0", mem_Abus, 1);
    wait_ack(0, 10);
    cyc();
    check("tie_idle_gap", busy, 0);
    cyc();
    check("tie2_p1_accept", {mem_Ain, mem_Abus}, {1'b1, 5'd3});
    wait_ack(1, 10);
    p1_req = 1'b0;
    wait_ack(0, 10);
    p0_req = 1'b0;
    cyc();

    // p0 held continuously: acks every 5 cycles, one IDLE between
    p0_req = 1'b1; p0_addr = 5'd3;
    for (int i = 0; i < 4; i++) sbq.push_back('{port: 0, rd: 1'b1, data: pat(3)});
    wait_ack(0, 10);
    for (int k = 0; k < 3; k++) begin
      cycles = 0; idle = 0;
      do begin
        cyc();
        cycles++;
        if (!busy) idle++;
      end while (!p0_ack && cycles < 20);
      check($sformatf("hold_period_%0d", k), cycles, 5);
      check($sformatf("hold_idle_%0d", k), idle, 1);
    end
    p0_req = 1'b0;
    cyc();

    // reset during WR of a port-1 write to addr 2
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 5'd2; p1_wdata = 8'h5A;
    cyc();
    cyc();
    check("rw_in_wr", mem_write, 1);
    RST = 1'b1; p1_req = 1'b0; p1_we = 1'b0;
    cyc();
    check("rw_outs_zero", {p0_ack, p1_ack, busy, mem_Ain, mem_Din, mem_read, mem_write,
                           mem_Dout, mem_dbus_oe}, 0);
    check("rw_abus_zero", mem_Abus, 0);
    check("rw_rdata_zero", rdata, 0);
    check("rw_dbus_o_zero", mem_dbus_o, 0);
    RST = 1'b0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 5'd1;
    sbq.push_back('{port: 1, rd: 1'b1, data: 8'hFF});
    wait_ack(1, 10);
    p1_req = 1'b0;
    cyc(); cyc();
    check("rw_mem2_ok", (mem[2] == pat(2)) || (mem[2] == 8'h5A), 1);

    check("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
